conv_z_writer: RTL and testbench

Result-side write sequencer for the convolution core: accepts accumulated output samples Z[n] from the MAC datapath over a valid/ready handshake and writes them to memZ at ascending addresses 0 … sizeX+sizeY−2. It is the writer counterpart of the descending Y-index counter on the read side. The read side walks memY downward per output sample; this block walks memZ upward once per convolution and reports completion to the top-level controller.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_cntrZ.sv | 40 ++++
 rtl/conv_z_writer.sv | 114 +++++++++++
 tb/tb_conv_z_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution core.
//   - default widths for the size inputs, the memZ address and one Z sample
//   - state encoding for the Z-side write sequencer
package conv_pkg;

  localparam int unsigned CONV_SIZE_WIDTH = 5;
  localparam int unsigned CONV_ADDR_WIDTH = 6;
  localparam int unsigned CONV_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } conv_zw_state_t;

endpackage

// File: rtl/conv_cntrZ.sv
// conv_cntrZ: ascending memZ index counter, the write-side twin of the
// read-side descending Y counter.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clr_i       load 0 (start of a convolution)
//   inc_i       advance by one (a sample was accepted)
//   n_o         current index
//   n_nxt_o     current index + 1 (adder output, also used for end detection)
module conv_cntrZ
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = CONV_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] n_o,
  output logic [WIDTH-1:0] n_nxt_o
);

  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] n_d;

  assign n_nxt_o = n_q + WIDTH'(1);

  // Two-way select: clear wins over increment.
  assign n_d = clr_i ? '0 : n_nxt_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q <= '0;
    end else if (clr_i || inc_i) begin
      n_q <= n_d;
    end
  end

  assign n_o = n_q;

endmodule

// File: rtl/conv_z_writer.sv
// conv_z_writer: result-side write sequencer. Takes Z samples from the MAC
// over valid/ready and writes them to memZ at addresses 0 .. sizeX+sizeY-2,
// then pulses done_out once.
//
// state | meaning
// IDLE  | waiting for start_in; sizes sampled here
// RUN   | ready_out=1, one write per accepted sample
// FLUSH | last write strobe on the bus, no more accepts
// DONE  | done_out pulse, back to IDLE next cycle
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start_in, sizeX_in/Y_in   start pulse and operand lengths
//   data_in, valid_in         Z sample and its valid
//   ready_out                 sample accepted this cycle if valid_in
//   memZ_addr/data/we_out     registered memZ write port
//   busy_out, done_out        status
module conv_z_writer
  import conv_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH = CONV_SIZE_WIDTH,
  parameter int unsigned ADDR_WIDTH = CONV_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_in,
  input  logic [SIZE_WIDTH-1:0] sizeX_in,
  input  logic [SIZE_WIDTH-1:0] sizeY_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [ADDR_WIDTH-1:0] memZ_addr_out,
  output logic [DATA_WIDTH-1:0] memZ_data_out,
  output logic                  memZ_we_out,
  output logic                  busy_out,
  output logic                  done_out
);

  conv_zw_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] total_q, total_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] n, n_nxt;
  logic                  clr_n;
  logic                  accept;

  assign ready_out = (state_q == RUN);
  assign busy_out  = (state_q == RUN) || (state_q == FLUSH);
  assign done_out  = (state_q == DONE);
  assign accept    = ready_out && valid_in;

  conv_cntrZ #(.WIDTH(ADDR_WIDTH)) u_cntrZ (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr_n),
    .inc_i   (accept),
    .n_o     (n),
    .n_nxt_o (n_nxt)
  );

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    clr_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          // Zero-extended to the address width, so max+max-1 cannot overflow.
          total_d = ADDR_WIDTH'(sizeX_in) + ADDR_WIDTH'(sizeY_in) - ADDR_WIDTH'(1);
          clr_n   = 1'b1;
          state_d = ((sizeX_in == '0) || (sizeY_in == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = n;
          data_d = data_in;
          // n+1 == total is the same as n == total-1, without a subtractor.
          if (n_nxt == total_q) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      total_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign memZ_addr_out = addr_q;
  assign memZ_data_out = data_q;
  assign memZ_we_out   = we_q;

endmodule

// File: tb/tb_conv_z_writer.sv
module tb_conv_z_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_in;
  logic [4:0]  sizeX_in, sizeY_in;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [5:0]  memZ_addr_out;
  logic [15:0] memZ_data_out;
  logic        memZ_we_out;
  logic        busy_out;
  logic        done_out;

  int checks   = 0;
  int failures = 0;

  conv_z_writer dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_in      (start_in),
    .sizeX_in      (sizeX_in),
    .sizeY_in      (sizeY_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .memZ_addr_out (memZ_addr_out),
    .memZ_data_out (memZ_data_out),
    .memZ_we_out   (memZ_we_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [4:0] sx, input logic [4:0] sy);
    start_in = 1'b1;
    sizeX_in = sx;
    sizeY_in = sy;
    tick();
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_in = 1'b0; sizeX_in = '0; sizeY_in = '0;
    data_in = '0; valid_in = 1'b0;
    tick(); tick();
    checks++;
    if ({ready_out, busy_out, done_out, memZ_we_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status got r=%b b=%b d=%b we=%b expected all 0",
               ready_out, busy_out, done_out, memZ_we_out);
    end
    checks++;
    if (memZ_addr_out !== 6'd0 || memZ_data_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0d data=%0d expected 0/0", memZ_addr_out, memZ_data_out);
    end
    rstn = 1'b1;
    tick();
  endtask

  // 3+2-1 = 4 writes with valid held high, also through FLUSH and DONE.
  task automatic test_basic();
    start_run(5'd3, 5'd2);
    checks++;
    if (busy_out !== 1'b1 || ready_out !== 1'b1 || memZ_we_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_enter_run got b=%b r=%b we=%b expected 1 1 0", busy_out, ready_out, memZ_we_out);
    end
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'(10 + i);
      tick();
      checks++;
      if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'(i) || memZ_data_out !== 16'(10 + i)) begin
        failures++;
        $display("FAIL basic_write%0d got we=%b addr=%0d data=%0d expected 1 %0d %0d",
                 i, memZ_we_out, memZ_addr_out, memZ_data_out, i, 10 + i);
      end
      checks++;
      if (ready_out !== (i < 3)) begin
        failures++;
        $display("FAIL basic_ready%0d got %b expected %b", i, ready_out, (i < 3));
      end
    end
    data_in = 16'd99;
    tick();
    checks++;
    if (done_out !== 1'b1 || memZ_we_out !== 1'b0 || busy_out !== 1'b0 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got d=%b we=%b b=%b r=%b expected 1 0 0 0",
               done_out, memZ_we_out, busy_out, ready_out);
    end
    tick();
    checks++;
    if (done_out !== 1'b0 || memZ_we_out !== 1'b0 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got d=%b we=%b r=%b expected 0 0 0", done_out, memZ_we_out, ready_out);
    end
    valid_in = 1'b0;
  endtask

  // Started in the first IDLE cycle after DONE; 2+2-1 = 3 writes, valid 1,0,0,1,1.
  task automatic test_gapped();
    logic [4:0] pat;
    int exp_addr;
    pat = 5'b11001;  // bit 0 first
    exp_addr = 0;
    start_run(5'd2, 5'd2);
    for (int k = 0; k < 5; k++) begin
      valid_in = pat[k];
      data_in  = 16'(20 + k);
      tick();
      if (pat[k]) begin
        checks++;
        if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'(exp_addr) || memZ_data_out !== 16'(20 + k)) begin
          failures++;
          $display("FAIL gapped_write%0d got we=%b addr=%0d data=%0d expected 1 %0d %0d",
                   k, memZ_we_out, memZ_addr_out, memZ_data_out, exp_addr, 20 + k);
        end
        exp_addr++;
      end else begin
        checks++;
        if (memZ_we_out !== 1'b0) begin
          failures++;
          $display("FAIL gapped_gap%0d got we=%b expected 0", k, memZ_we_out);
        end
      end
      checks++;
      if (busy_out !== 1'b1 || done_out !== 1'b0) begin
        failures++;
        $display("FAIL gapped_busy%0d got b=%b d=%b expected 1 0", k, busy_out, done_out);
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b0 || memZ_we_out !== 1'b0) begin
      failures++;
      $display("FAIL gapped_done got d=%b b=%b we=%b expected 1 0 0", done_out, busy_out, memZ_we_out);
    end
    tick();
  endtask

  task automatic test_zero();
    valid_in = 1'b1;
    start_run(5'd0, 5'd7);
    checks++;
    if (done_out !== 1'b1 || memZ_we_out !== 1'b0 || busy_out !== 1'b0 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got d=%b we=%b b=%b r=%b expected 1 0 0 0",
               done_out, memZ_we_out, busy_out, ready_out);
    end
    tick();
    checks++;
    if (done_out !== 1'b0 || memZ_we_out !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got d=%b we=%b b=%b expected 0 0 0", done_out, memZ_we_out, busy_out);
    end
    valid_in = 1'b0;
  endtask

  // 2+3-1 = 4 writes; a start with sizeX=9 arrives after the second accept.
  task automatic test_start_busy();
    start_run(5'd2, 5'd3);
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'(40 + i);
      if (i == 2) begin
        start_in = 1'b1; sizeX_in = 5'd9; sizeY_in = 5'd9;
      end else begin
        start_in = 1'b0;
      end
      tick();
      checks++;
      if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'(i) || memZ_data_out !== 16'(40 + i)) begin
        failures++;
        $display("FAIL busy_start_write%0d got we=%b addr=%0d data=%0d expected 1 %0d %0d",
                 i, memZ_we_out, memZ_addr_out, memZ_data_out, i, 40 + i);
      end
    end
    start_in = 1'b0;
    checks++;
    if (ready_out !== 1'b0 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_flush got r=%b b=%b expected 0 1", ready_out, busy_out);
    end
    tick();
    checks++;
    if (done_out !== 1'b1 || memZ_we_out !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_done got d=%b we=%b expected 1 0", done_out, memZ_we_out);
    end
    valid_in = 1'b0;
    tick();
  endtask

  // 31+31-1 = 61 writes, addresses 0..60; valid stays high afterwards.
  task automatic test_max();
    int bad;
    bad = 0;
    start_run(5'd31, 5'd31);
    valid_in = 1'b1;
    for (int i = 0; i < 61; i++) begin
      data_in = 16'(1000 + 3 * i);
      tick();
      if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'(i) || memZ_data_out !== 16'(1000 + 3 * i)) begin
        if (bad == 0)
          $display("FAIL max_write%0d got we=%b addr=%0d data=%0d expected 1 %0d %0d",
                   i, memZ_we_out, memZ_addr_out, memZ_data_out, i, 1000 + 3 * i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (memZ_addr_out !== 6'd60 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL max_last got addr=%0d r=%b expected 60 0", memZ_addr_out, ready_out);
    end
    tick();
    checks++;
    if (done_out !== 1'b1 || memZ_we_out !== 1'b0 || ready_out !== 1'b0) begin
      failures++;
      $display("FAIL max_done got d=%b we=%b r=%b expected 1 0 0", done_out, memZ_we_out, ready_out);
    end
    tick();
    tick();
    checks++;
    if (memZ_we_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || memZ_addr_out !== 6'd60) begin
      failures++;
      $display("FAIL max_idle_valid got we=%b b=%b d=%b addr=%0d expected 0 0 0 60",
               memZ_we_out, busy_out, done_out, memZ_addr_out);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    start_run(5'd2, 5'd3);
    valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_in = 16'(60 + i);
      tick();
    end
    checks++;
    if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'd1) begin
      failures++;
      $display("FAIL rstmid_pre got we=%b addr=%0d expected 1 1", memZ_we_out, memZ_addr_out);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({ready_out, busy_out, done_out, memZ_we_out} !== 4'b0000 ||
        memZ_addr_out !== 6'd0 || memZ_data_out !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_now got r=%b b=%b d=%b we=%b addr=%0d data=%0d expected all 0",
               ready_out, busy_out, done_out, memZ_we_out, memZ_addr_out, memZ_data_out);
    end
    tick(); tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_out !== 1'b0 || memZ_we_out !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL rstmid_quiet got %0d active cycles expected 0", seen_done);
    end
    valid_in = 1'b0;
    start_run(5'd1, 5'd1);
    valid_in = 1'b1;
    data_in  = 16'd77;
    tick();
    checks++;
    if (memZ_we_out !== 1'b1 || memZ_addr_out !== 6'd0 || memZ_data_out !== 16'd77) begin
      failures++;
      $display("FAIL rstmid_fresh got we=%b addr=%0d data=%0d expected 1 0 77",
               memZ_we_out, memZ_addr_out, memZ_data_out);
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (done_out !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_fresh_done got %b expected 1", done_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero();
    test_start_busy();
    test_max();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
